// File: rtl/mac_datapath.sv
// Signed multiply-accumulate datapath with saturating result buffer and registered read port.
// Operands are captured into registers, their product is accumulated, and saturated results are stored.
module mac_datapath #(
    parameter  int N     = 8,
    parameter  int d     = 4,
    parameter  int Q     = 4,
    localparam int AW    = (Q > 1) ? $clog2(Q) : 1,
    localparam int CW    = $clog2(Q) + 1,
    localparam int ACC_W = 2 * N + $clog2(d)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [N-1:0]     x_in,
    input  logic signed [N-1:0]     w_in,
    input  logic                    write_x,
    input  logic                    write_w,
    input  logic                    acc_write,
    input  logic                    clear_acc,
    input  logic                    res_write,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic signed [ACC_W-1:0] acc_out,
    output logic signed [N-1:0]     rd_data,
    output logic                    rd_valid,
    output logic [CW-1:0]           res_count,
    output logic                    full,
    output logic                    overflow
);

    logic signed [N-1:0]     x_q, x_d;
    logic signed [N-1:0]     w_q, w_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [N-1:0]     rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic signed [N-1:0]     buf_q [Q];

    logic signed [ACC_W-1:0] x_ext, w_ext, prod, acc_base;
    logic [ACC_W-N:0]        acc_upper;
    logic                    acc_fits;
    logic signed [N-1:0]     sat_val;
    logic signed [N-1:0]     rd_sel;
    logic                    wr_en;

    // Extending both operands to accumulator width keeps the product exact and already sign-extended.
    assign x_ext = $signed({{(ACC_W-N){x_q[N-1]}}, x_q});
    assign w_ext = $signed({{(ACC_W-N){w_q[N-1]}}, w_q});
    assign prod  = x_ext * w_ext;

    // The accumulator fits in N signed bits only when every bit from N-1 upward equals the sign.
    assign acc_upper = acc_q[ACC_W-1:N-1];
    assign acc_fits  = (&acc_upper) | ~(|acc_upper);
    assign sat_val   = acc_fits ? acc_q[N-1:0]
                     : (acc_q[ACC_W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});

    assign full  = (cnt_q == CW'(Q));
    assign wr_en = res_write & ~full;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        rd_sel = '0;
        for (int i = 0; i < Q; i++) begin
            if (rd_addr == AW'(i)) rd_sel = buf_q[i];
        end
    end

    always_comb begin
        x_d        = write_x ? x_in : x_q;
        w_d        = write_w ? w_in : w_q;
        acc_base   = clear_acc ? '0 : acc_q;
        acc_d      = acc_write ? acc_base + prod : acc_base;
        cnt_d      = wr_en ? cnt_q + CW'(1) : cnt_q;
        ovf_d      = ovf_q | (res_write & full);
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_sel : rd_data_q;
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            w_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            w_q        <= w_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // NOTE: the result buffer is built from resettable flops, since reset must empty it and unwritten entries read as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Q; i++) buf_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < Q; i++) begin
                if (cnt_q == CW'(i)) buf_q[i] <= sat_val;
            end
        end
    end

    assign acc_out   = acc_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign res_count = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_datapath.sv
// Directed self-checking bench for mac_datapath; a second instance with Q=5 exercises
// out-of-range addressing and same-cycle read/write of one entry.
module tb_mac_datapath;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [7:0]  x_in, w_in;
    logic               write_x, write_w, acc_write, clear_acc, res_write, rd_en;
    logic [1:0]         rd_addr;
    logic [2:0]         rd_addr5;

    logic signed [17:0] acc_out, acc_out5;
    logic signed [7:0]  rd_data, rd_data5;
    logic               rd_valid, rd_valid5;
    logic [2:0]         res_count;
    logic [3:0]         res_count5;
    logic               full, full5, overflow, overflow5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_datapath #(.N(8), .d(4), .Q(4)) u_dut (
        .clk(clk), .rst(rst), .x_in(x_in), .w_in(w_in),
        .write_x(write_x), .write_w(write_w), .acc_write(acc_write),
        .clear_acc(clear_acc), .res_write(res_write), .rd_en(rd_en),
        .rd_addr(rd_addr), .acc_out(acc_out), .rd_data(rd_data),
        .rd_valid(rd_valid), .res_count(res_count), .full(full),
        .overflow(overflow)
    );

    mac_datapath #(.N(8), .d(4), .Q(5)) u_dut5 (
        .clk(clk), .rst(rst), .x_in(x_in), .w_in(w_in),
        .write_x(write_x), .write_w(write_w), .acc_write(acc_write),
        .clear_acc(clear_acc), .res_write(res_write), .rd_en(rd_en),
        .rd_addr(rd_addr5), .acc_out(acc_out5), .rd_data(rd_data5),
        .rd_valid(rd_valid5), .res_count(res_count5), .full(full5),
        .overflow(overflow5)
    );

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_x = 0; write_w = 0; acc_write = 0; clear_acc = 0;
        res_write = 0; rd_en = 0;
    endtask

    task automatic load_mac(input int x, input int w);
        x_in = 8'(x); w_in = 8'(w); write_x = 1; write_w = 1;
        cyc();
        write_x = 0; write_w = 0; acc_write = 1;
        cyc();
        acc_write = 0;
    endtask

    task automatic dot_seq();
        load_mac(1, 5); load_mac(2, 6); load_mac(3, 7); load_mac(4, 8);
    endtask

    task automatic read_buf(input int addr, input int addr5);
        rd_addr = 2'(addr); rd_addr5 = 3'(addr5); rd_en = 1;
        cyc();
        rd_en = 0;
    endtask

    initial begin
        rst = 1; x_in = 0; w_in = 0; rd_addr = 0; rd_addr5 = 0;
        idle();
        #3;
        check("rst_acc", int'(acc_out), 0);
        check("rst_count", int'(res_count), 0);
        check("rst_full", int'(full), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        rst = 0;

        // Basic dot product 1*5+2*6+3*7+4*8
        dot_seq();
        check("dot_acc", int'(acc_out), 70);
        res_write = 1; cyc(); res_write = 0;
        check("dot_count", int'(res_count), 1);
        check("dot_full", int'(full), 0);
        read_buf(0, 5);
        check("rd0_data", int'(rd_data), 70);
        check("rd0_valid", int'(rd_valid), 1);
        check("rd_oob_data", int'(rd_data5), 0);
        cyc();
        check("rd_valid_drop", int'(rd_valid), 0);
        read_buf(2, 0);
        check("rd_unwritten", int'(rd_data), 0);

        // Clear+accumulate together, with a store of the pre-clear value
        x_in = 3; w_in = -2; write_x = 1; write_w = 1;
        cyc();
        idle();
        clear_acc = 1; acc_write = 1; res_write = 1;
        cyc();
        idle();
        check("clr_add_acc", int'(acc_out), -6);
        check("clr_add_count", int'(res_count), 2);
        read_buf(1, 0);
        check("clr_add_stored", int'(rd_data), 70);

        // Positive saturation
        clear_acc = 1; cyc(); idle();
        check("clear_only", int'(acc_out), 0);
        x_in = 127; w_in = 127; write_x = 1; write_w = 1; cyc(); idle();
        acc_write = 1; repeat (4) cyc(); idle();
        check("pos_acc", int'(acc_out), 64516);
        res_write = 1; cyc(); idle();
        read_buf(2, 0);
        check("pos_sat", int'(rd_data), 127);

        // Negative saturation, fills the Q=4 buffer
        clear_acc = 1; cyc(); idle();
        x_in = -128; write_x = 1; cyc(); idle();
        acc_write = 1; repeat (4) cyc(); idle();
        check("neg_acc", int'(acc_out), -65024);
        res_write = 1; cyc(); idle();
        check("fill_count", int'(res_count), 4);
        check("fill_full", int'(full), 1);
        check("fill_ovf", int'(overflow), 0);
        check("q5_not_full", int'(full5), 0);

        // Fifth write: dropped on Q=4, same-cycle read/write of entry 4 on Q=5
        clear_acc = 1; cyc(); idle();
        x_in = 1; w_in = 1; write_x = 1; write_w = 1; cyc(); idle();
        acc_write = 1; cyc(); idle();
        check("one_acc", int'(acc_out), 1);
        res_write = 1; rd_en = 1; rd_addr = 3; rd_addr5 = 4;
        cyc();
        idle();
        check("drop_count", int'(res_count), 4);
        check("drop_ovf", int'(overflow), 1);
        check("neg_sat", int'(rd_data), -128);
        check("rw_same_old", int'(rd_data5), 0);
        check("q5_count", int'(res_count5), 5);
        check("q5_full", int'(full5), 1);
        check("q5_ovf", int'(overflow5), 0);
        read_buf(3, 4);
        check("buf3_kept", int'(rd_data), -128);
        check("rw_same_new", int'(rd_data5), 1);
        read_buf(2, 0);

        // Asynchronous reset between two accumulations
        clear_acc = 1; cyc(); idle();
        load_mac(1, 5);
        check("pre_rst_acc", int'(acc_out), 5);
        rst = 1;
        #1;
        check("arst_acc", int'(acc_out), 0);
        check("arst_count", int'(res_count), 0);
        check("arst_full", int'(full), 0);
        check("arst_ovf", int'(overflow), 0);
        check("arst_rd_data", int'(rd_data), 0);
        #1;
        rst = 0;
        dot_seq();
        check("rerun_acc", int'(acc_out), 70);
        res_write = 1; cyc(); idle();
        check("rerun_count", int'(res_count), 1);
        read_buf(0, 0);
        check("rerun_stored", int'(rd_data), 70);
        read_buf(1, 0);
        check("rerun_cleared", int'(rd_data), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_datapath.md
MAC_DATAPATH -- requirements
Module: mac_datapath

Parameters
REQ-001 SHALL have parameter N, default 8: signed two's-complement width of operand x, operand w and the stored result.
REQ-002 SHALL have parameter d, default 4: dot-product length, which sizes the accumulator.
REQ-003 SHALL have parameter Q, default 4: depth of the result buffer, i.e. the number of neuron outputs it holds.

Interface
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 x_in  in  N  operand x (signed).
REQ-007 w_in  in  N  operand w (signed).
REQ-008 write_x  in  1  capture x_in into x_reg.
REQ-009 write_w  in  1  capture w_in into w_reg.
REQ-010 acc_write  in  1  accumulate x_reg*w_reg.
REQ-011 clear_acc  in  1  zero the accumulator.
REQ-012 res_write  in  1  push the saturated accumulator value into the result buffer.
REQ-013 rd_en  in  1  read request.
REQ-014 rd_addr  in  clog2(Q)  buffer index to read.
REQ-015 acc_out  out  2N+clog2(d)  live accumulator value (signed).
REQ-016 rd_data  out  N  registered read data.
REQ-017 rd_valid  out  1  rd_data valid; one-cycle pulse.
REQ-018 res_count  out  clog2(Q)+1  number of stored results.
REQ-019 full  out  1  high when res_count==Q.
REQ-020 overflow  out  1  sticky flag: a res_write was dropped.

Function
REQ-021 On a rising edge with write_x=1, x_reg SHALL load x_in; write_w/w_reg SHALL behave identically and independently.
REQ-022 The product SHALL be the full-precision signed 2N-bit x_reg*w_reg, taken from the register values before that edge's update, and sign-extended to accumulator width.
REQ-023 On an edge with acc_write=1 and clear_acc=0, acc SHALL take acc+product.
REQ-024 On an edge with clear_acc=1 and acc_write=0, acc SHALL take 0.
REQ-025 On an edge with clear_acc=1 and acc_write=1, acc SHALL take product (clear first, then add).
REQ-026 The accumulator SHALL NOT wrap for d or fewer accumulations; behaviour beyond d accumulations is wrap-around modulo the accumulator width.
REQ-027 Saturation SHALL clamp acc to the range [-2^(N-1), 2^(N-1)-1].
REQ-028 On an edge with res_write=1 and full=0, the saturated acc SHALL be written to entry res_count, and res_count SHALL increment.
REQ-029 On an edge with res_write=1 and full=1, the write SHALL be dropped, buffer contents and res_count SHALL be unchanged, and overflow SHALL be set.
REQ-030 res_write and acc_write in the same cycle: the stored value SHALL be based on acc before that edge's update.
REQ-031 res_write and clear_acc in the same cycle: the stored value SHALL be the pre-clear acc.
REQ-032 Read: rd_en=1 at edge k SHALL give rd_data=buf[rd_addr] and rd_valid=1 after edge k.
REQ-033 rd_valid SHALL return to 0 at the next edge unless rd_en is held.
REQ-034 An out-of-range rd_addr (>=Q) SHALL return 0.
REQ-035 A read of an entry not yet written SHALL return 0.
REQ-036 Read and write to the same entry in the same cycle SHALL return the old content.
REQ-037 full SHALL be combinational from res_count.
REQ-038 res_count SHALL not decrement; the buffer is emptied only by rst.

Reset
REQ-039 rst=1 SHALL immediately, without waiting for clk, clear x_reg, w_reg, acc, every buffer entry, res_count, rd_data, rd_valid, full and overflow to 0.
REQ-040 Reset asserted mid-accumulation SHALL discard partial sums; the first edge after deassertion behaves as from power-up.

Verification
REQ-041 N=8, d=4: x=[1,2,3,4], w=[5,6,7,8], each captured then accumulated, then res_write -> acc_out=70, buf[0]=70, res_count=1.
REQ-042 x=127, w=127 accumulated 4x -> acc_out=64516, stored value 127; x=-128, w=127 accumulated 4x -> acc_out=-65024, stored value -128.
REQ-043 acc=70 with clear_acc=1, acc_write=1, x_reg=3, w_reg=-2 -> acc_out=-6; same cycle with res_write=1 -> stored value 70.
REQ-044 Q=4: five res_writes -> res_count=4, full=1, overflow=1, buf[3] unchanged by the fifth write.
REQ-045 rd_en=1, rd_addr=0 after REQ-041 -> next cycle rd_data=70, rd_valid=1; rd_addr=5 -> rd_data=0.
REQ-046 rst pulsed asynchronously between two acc_writes -> all outputs 0 immediately; the REQ-041 sequence rerun gives 70.
